// File: rtl/mult12_seq_ctrl.sv
// 12x12 unsigned multiply sequencer driving one external pipelined 6x6 core.
// Four partial products are issued back to back and accumulated as they return.
module mult12_seq_ctrl #(
    parameter int CORE_LAT = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [11:0] in_a,
    input  logic [11:0] in_b,
    output logic [5:0]  core_a,
    output logic [5:0]  core_b,
    input  logic [11:0] core_c,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [23:0] out_prod,
    output logic        busy
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    // Every tag stage except the one exiting this cycle.
    localparam logic [CORE_LAT-1:0] HOLD_MASK = {CORE_LAT{1'b1}} >> 1;

    logic [1:0]  state_q, state_d;
    logic [1:0]  idx_q, idx_d;
    logic [11:0] a_q, a_d;
    logic [11:0] b_q, b_d;
    logic [23:0] acc_q, acc_d;
    logic [23:0] prod_q, prod_d;

    logic [CORE_LAT-1:0]      tv_q;
    logic [CORE_LAT-1:0][1:0] ts_q;
    logic                     push;
    logic [1:0]               push_s;
    logic [3:0]               shamt;

    always_comb begin
        unique case (ts_q[CORE_LAT-1])
            2'd1:    shamt = 4'd6;
            2'd2:    shamt = 4'd12;
            default: shamt = 4'd0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        prod_d  = prod_q;
        push    = 1'b0;
        push_s  = 2'd0;
        acc_d   = acc_q;
        if (tv_q[CORE_LAT-1]) begin
            acc_d = acc_q + ({12'd0, core_c} << shamt);
        end
        unique case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    a_d     = in_a;
                    b_d     = in_b;
                    acc_d   = '0;
                    idx_d   = 2'd0;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                push = 1'b1;
                unique case (idx_q)
                    2'd0:    push_s = 2'd0;
                    2'd3:    push_s = 2'd2;
                    default: push_s = 2'd1;
                endcase
                idx_d = idx_q + 2'd1;
                if (idx_q == 2'd3) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (~|(tv_q & HOLD_MASK)) begin
                    prod_d  = acc_d;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            prod_q  <= '0;
            tv_q    <= '0;
            ts_q    <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            prod_q  <= prod_d;
            for (int i = CORE_LAT - 1; i > 0; i--) begin
                tv_q[i] <= tv_q[i-1];
                ts_q[i] <= ts_q[i-1];
            end
            tv_q[0] <= push;
            ts_q[0] <= push_s;
        end
    end

    always_comb begin
        core_a = '0;
        core_b = '0;
        if (state_q == S_ISSUE) begin
            core_a = idx_q[0] ? a_q[11:6] : a_q[5:0];
            core_b = idx_q[1] ? b_q[11:6] : b_q[5:0];
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q != S_IDLE);
    assign out_prod  = prod_q;

endmodule

// File: tb/tb_mult12_seq_ctrl.sv
// Bench for mult12_seq_ctrl: three instances (core latency 2, 1, 4),
// each fed by a delayed-product core model, checked against a scoreboard.
`timescale 1ns/1ps
module tb_mult12_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        iv = 1'b0;
    logic        out_ready = 1'b1;
    logic [11:0] in_a = '0;
    logic [11:0] in_b = '0;
    int          sel = 2;

    logic        iv1, iv2, iv4;
    logic        ir1, ir2, ir4;
    logic        ov1, ov2, ov4;
    logic        bz1, bz2, bz4;
    logic [23:0] op1, op2, op4;
    logic [5:0]  ca1, ca2, ca4, cb1, cb2, cb4;
    logic [11:0] cc1, cc2, cc4;

    logic [11:0] p1 [1];
    logic [11:0] p2 [2];
    logic [11:0] p4 [4];

    logic        ir, ov, bz;
    logic [23:0] op;
    logic [5:0]  ca, cb;

    int checks = 0;
    int failures = 0;
    logic [23:0] sbq [$];

    always #5 clk = ~clk;

    assign iv1 = iv && (sel == 1);
    assign iv2 = iv && (sel == 2);
    assign iv4 = iv && (sel == 4);

    always @(posedge clk) begin
        p1[0] <= {6'd0, ca1} * {6'd0, cb1};
        p2[0] <= {6'd0, ca2} * {6'd0, cb2};
        p2[1] <= p2[0];
        p4[0] <= {6'd0, ca4} * {6'd0, cb4};
        for (int k = 1; k < 4; k++) p4[k] <= p4[k-1];
    end
    assign cc1 = p1[0];
    assign cc2 = p2[1];
    assign cc4 = p4[3];

    mult12_seq_ctrl #(.CORE_LAT(2)) dut (
        .clk(clk), .rst(rst), .in_valid(iv2), .in_ready(ir2),
        .in_a(in_a), .in_b(in_b), .core_a(ca2), .core_b(cb2),
        .core_c(cc2), .out_valid(ov2), .out_ready(out_ready),
        .out_prod(op2), .busy(bz2)
    );

    mult12_seq_ctrl #(.CORE_LAT(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1),
        .in_a(in_a), .in_b(in_b), .core_a(ca1), .core_b(cb1),
        .core_c(cc1), .out_valid(ov1), .out_ready(out_ready),
        .out_prod(op1), .busy(bz1)
    );

    mult12_seq_ctrl #(.CORE_LAT(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(ir4),
        .in_a(in_a), .in_b(in_b), .core_a(ca4), .core_b(cb4),
        .core_c(cc4), .out_valid(ov4), .out_ready(out_ready),
        .out_prod(op4), .busy(bz4)
    );

    always_comb begin
        ir = ir2; ov = ov2; bz = bz2; op = op2; ca = ca2; cb = cb2;
        if (sel == 1) begin
            ir = ir1; ov = ov1; bz = bz1; op = op1; ca = ca1; cb = cb1;
        end else if (sel == 4) begin
            ir = ir4; ov = ov4; bz = bz4; op = op4; ca = ca4; cb = cb4;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    function automatic logic [23:0] model(input logic [11:0] a,
                                          input logic [11:0] b);
        return {12'd0, a} * {12'd0, b};
    endfunction

    task automatic wait_result(input string tag, input int n0,
                               input int lat, output logic [23:0] e);
        int n;
        n = n0;
        while (!ov && n < 64) begin
            step();
            n++;
        end
        chk({tag, " latency"}, n, lat);
        e = 24'hxxxxxx;
        if (sbq.size() > 0) e = sbq.pop_front();
        chk({tag, " prod"}, {8'd0, op}, {8'd0, e});
    endtask

    task automatic run_op(input int s, input logic [11:0] a,
                          input logic [11:0] b, input int lat,
                          input string tag);
        logic [23:0] e;
        sel = s;
        in_a = a;
        in_b = b;
        iv = 1'b1;
        sbq.push_back(model(a, b));
        step();
        iv = 1'b0;
        in_a = 12'h5A5;
        in_b = 12'hA5A;
        wait_result(tag, 1, lat, e);
        out_ready = 1'b1;
        step();
        chk({tag, " drop"}, {31'd0, ov}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        logic [23:0] e;
        repeat (3) step();
        chk("rst in_ready", {31'd0, ir}, 32'd1);
        chk("rst out_valid", {31'd0, ov}, 32'd0);
        chk("rst busy", {31'd0, bz}, 32'd0);
        chk("rst core", {20'd0, ca, cb}, 32'd0);
        chk("rst prod", {8'd0, op}, 32'd0);
        rst = 1'b0;
        step();

        in_a = 12'hABC;
        in_b = 12'h123;
        iv = 1'b1;
        out_ready = 1'b1;
        sbq.push_back(model(12'hABC, 12'h123));
        step();
        iv = 1'b0;
        chk("s1 in_ready", {31'd0, ir}, 32'd0);
        chk("s1 core0", {20'd0, ca, cb}, {20'd0, 6'h3C, 6'h23});
        step();
        chk("s1 core1", {20'd0, ca, cb}, {20'd0, 6'h2A, 6'h23});
        step();
        chk("s1 core2", {20'd0, ca, cb}, {20'd0, 6'h3C, 6'h04});
        step();
        chk("s1 core3", {20'd0, ca, cb}, {20'd0, 6'h2A, 6'h04});
        step();
        chk("s1 core drain", {20'd0, ca, cb}, 32'd0);
        wait_result("s1", 5, 7, e);
        chk("s1 const", {8'd0, e}, 32'h0C33B4);
        step();
        chk("s1 drop", {31'd0, ov}, 32'd0);

        run_op(2, 12'hFFF, 12'hFFF, 7, "max");
        run_op(2, 12'h000, 12'h7A5, 7, "zero");
        run_op(2, 12'h001, 12'hFFF, 7, "one");

        out_ready = 1'b0;
        in_a = 12'h9D3;
        in_b = 12'h6E1;
        iv = 1'b1;
        sbq.push_back(model(12'h9D3, 12'h6E1));
        step();
        in_a = 12'h123;
        in_b = 12'h456;
        sbq.push_back(model(12'h123, 12'h456));
        wait_result("hold", 1, 7, e);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("hold valid", {31'd0, ov}, 32'd1);
            chk("hold prod", {8'd0, op}, {8'd0, e});
            chk("hold in_ready", {31'd0, ir}, 32'd0);
        end
        out_ready = 1'b1;
        step();
        chk("hold idle", {30'd0, ov, ir}, 32'd1);
        step();
        chk("hold accept", {31'd0, bz}, 32'd1);
        iv = 1'b0;
        wait_result("pend", 1, 7, e);
        step();

        in_a = 12'h555;
        in_b = 12'h3AA;
        iv = 1'b1;
        step();
        iv = 1'b0;
        step();
        step();
        rst = 1'b1;
        #1;
        for (int i = 0; i < 2; i++) begin
            chk("arst ready", {31'd0, ir}, 32'd1);
            chk("arst valid", {30'd0, ov, bz}, 32'd0);
            chk("arst core", {20'd0, ca, cb}, 32'd0);
            chk("arst prod", {8'd0, op}, 32'd0);
            step();
        end
        rst = 1'b0;
        step();
        run_op(2, 12'h800, 12'h800, 7, "post rst");
        chk("post rst const", {8'd0, op}, 32'h400000);

        run_op(1, 12'hABC, 12'h123, 6, "lat1");
        run_op(4, 12'hABC, 12'h123, 9, "lat4");
        run_op(4, 12'hFFF, 12'hFFF, 9, "lat4 max");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
